// File: rtl/inv_arb_pkg.sv
// inv_arb_pkg: shared constants and types for the round-robin inverter arbiter.
package inv_arb_pkg;
    localparam int N_REQ = 4;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef logic [1:0] id_t;
endpackage

// File: rtl/inv_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, search starts at i_ptr and wraps 3 -> 0.
module rr_pick
    import inv_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  id_t              i_ptr,
    output logic             o_valid,
    output id_t              o_index,
    output logic [N_REQ-1:0] o_onehot
);
    id_t w_cand;
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        w_cand  = '0;
        // Scan farthest-first so the candidate closest to i_ptr is written last and wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = i_ptr + id_t'(k);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_index = w_cand;
            end
        end
        o_onehot = o_valid ? (N_REQ'(1) << o_index) : '0;
    end
endmodule

// File: rtl/inv_arbiter.sv
// inv_arbiter: four requesters share one bitwise inverter, granted round-robin,
// one transaction at a time (IDLE -> EXEC -> RESP).
module inv_arbiter
    import inv_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output id_t                    out_id,
    input  logic                   out_ready
);
    state_t           r_state, w_next;
    id_t              r_ptr, r_win;
    logic [WIDTH-1:0] r_opnd;
    logic             w_valid, w_accept, w_release;
    id_t              w_idx;
    logic [N_REQ-1:0] w_onehot;

    rr_pick u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_index  (w_idx),
        .o_onehot (w_onehot)
    );

    always_comb begin
        w_accept  = (r_state == IDLE) && w_valid;
        w_release = (r_state == RESP) && out_ready;
        w_next    = (r_state == IDLE) ? (w_valid ? EXEC : IDLE) :
                    (r_state == EXEC) ? RESP :
                    (out_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            r_ptr     <= '0;
            r_win     <= '0;
            r_opnd    <= '0;
        end else begin
            gnt <= w_accept ? w_onehot : '0;
            if (w_accept) begin
                r_opnd <= req_data[int'(w_idx)*WIDTH +: WIDTH];
                r_win  <= w_idx;
            end
            if (r_state == EXEC) begin
                out_data  <= ~r_opnd;
                out_id    <= r_win;
                out_valid <= 1'b1;
            end else if (w_release) begin
                out_valid <= 1'b0;
                r_ptr     <= r_win + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_inv_arbiter.sv
// tb_inv_arbiter: directed vectors with hand-computed results for inv_arbiter.
`timescale 1ns/1ps
module tb_inv_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready = 1'b1;
    int          n_chk = 0;
    int          n_err = 0;

    inv_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic single(input logic [1:0] id, input logic [7:0] d, input logic [7:0] q);
        req_data[id*8 +: 8] = d;
        req = 4'b1 << id;
        @(negedge clk);
        chk("single_gnt", gnt, 4'b1 << id);
        chk("single_nv", out_valid, 0);
        req = '0;
        @(negedge clk);
        chk("single_gnt0", gnt, 0);
        chk("single_v", out_valid, 1);
        chk("single_data", out_data, q);
        chk("single_id", out_id, id);
        @(negedge clk);
        chk("single_done", out_valid, 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_v", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_id", out_id, 0);
        rst = 1'b0;
        @(negedge clk);
        single(2'd0, 8'hA5, 8'h5A);
        single(2'd0, 8'h00, 8'hFF);
        single(2'd0, 8'hFF, 8'h00);
        // ptr is now 1: requester 2 wins, then backpressure holds the result
        req_data[23:16] = 8'h33;
        req = 4'b0100;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_gnt", gnt, 4'b0100);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_v", out_valid, 1);
            chk("bp_data", out_data, 8'hCC);
            chk("bp_id", out_id, 2);
            chk("bp_gnt0", gnt, 0);
        end
        out_ready = 1'b1;
        req = '0;
        @(negedge clk);
        chk("bp_release", out_valid, 0);
        chk("bp_rel_gnt", gnt, 0);
        // ptr is now 3: req 1001 gives 3 then 0
        req_data[31:24] = 8'h0F;
        req_data[7:0]   = 8'hF0;
        req = 4'b1001;
        @(negedge clk);
        chk("wrap_gnt3", gnt, 4'b1000);
        @(negedge clk);
        chk("wrap_id3", out_id, 3);
        chk("wrap_data3", out_data, 8'hF0);
        @(negedge clk);
        chk("wrap_idle", gnt, 0);
        @(negedge clk);
        chk("wrap_gnt0", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        chk("wrap_id0", out_id, 0);
        chk("wrap_data0", out_data, 8'h0F);
        @(negedge clk);
        // ptr is now 1: requester 1, then reset while the result is pending
        req_data[15:8] = 8'h0F;
        req = 4'b0010;
        out_ready = 1'b0;
        @(negedge clk);
        chk("mid_gnt", gnt, 4'b0010);
        req = '0;
        @(negedge clk);
        chk("mid_v", out_valid, 1);
        chk("mid_data", out_data, 8'hF0);
        #2 rst = 1'b1;
        #1;
        chk("async_v", out_valid, 0);
        chk("async_data", out_data, 0);
        chk("async_id", out_id, 0);
        chk("async_gnt", gnt, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        req_data = 32'h44332211;
        req = 4'b1111;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            case (j % 3)
                0: begin
                    chk("cont_gnt", gnt, 4'b1 << ((j / 3) % 4));
                    chk("cont_nv", out_valid, 0);
                end
                1: begin
                    chk("cont_gnt0", gnt, 0);
                    chk("cont_v", out_valid, 1);
                    chk("cont_id", out_id, (j / 3) % 4);
                    chk("cont_data", out_data, ~(8'h11 * (((j / 3) % 4) + 1)) & 8'hFF);
                end
                default: begin
                    chk("cont_gap", gnt, 0);
                    chk("cont_done", out_valid, 0);
                end
            endcase
        end
        req = '0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
